// File: rtl/pulse_timer_if.sv
// Control/status bundle for pulse_timer: run control and period load
// from the host side, tick/busy/done/count back from the timer.
`timescale 1ns/1ps

interface pulse_timer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             enable;
  logic             start;
  logic             stop;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] period_in;
  logic             tick;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  // Host side: drives control, observes status
  modport master (
    output enable, start, stop, mode, load, period_in,
    input  tick, busy, done, count
  );

  // Timer side: observes control, drives status
  modport slave (
    input  enable, start, stop, mode, load, period_in,
    output tick, busy, done, count
  );
endinterface

// File: rtl/pulse_timer.sv
// Programmable period timer with prescaler. Counts 0..period-1 while
// running, pulses tick for one cycle on each wrap, and either keeps
// running (periodic) or parks in DONE with a sticky done flag (one-shot).
`timescale 1ns/1ps

module pulse_timer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = 10,
  parameter int unsigned PRESCALE       = 1
) (
  input  logic          clk,
  input  logic          reset,
  pulse_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A one-bit prescaler is kept even for PRESCALE == 1; it simply never
  // leaves zero because its last value is also zero.
  localparam int unsigned      PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(DEFAULT_PERIOD);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;
  logic             r_mode;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_period_eff;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_tick_nxt;
  logic             w_done_nxt;
  logic             w_mode_nxt;
  logic [WIDTH-1:0] w_period_nxt;
  logic [WIDTH-1:0] w_period_eff_nxt;
  logic             w_step;
  logic             w_last;

  // A step happens when the prescaler completes while running and enabled
  assign w_step = (r_state == S_RUN) && bus.enable && (r_presc == PRE_LAST);
  assign w_last = (r_count == (r_period_eff - WIDTH'(1)));

  // State and output registers; reset overrides every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_presc      <= '0;
      r_tick       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mode       <= 1'b0;
      r_period     <= PERIOD_RST;
      r_period_eff <= PERIOD_RST;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_presc      <= w_presc_nxt;
      r_tick       <= w_tick_nxt;
      r_busy       <= (w_state_nxt == S_RUN);
      r_done       <= w_done_nxt;
      r_mode       <= w_mode_nxt;
      r_period     <= w_period_nxt;
      r_period_eff <= w_period_eff_nxt;
    end
  end

  // Next-state logic: stop beats start, start beats counting
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_presc_nxt      = r_presc;
    w_tick_nxt       = 1'b0;
    w_done_nxt       = r_done;
    w_mode_nxt       = r_mode;
    w_period_eff_nxt = r_period_eff;

    // Zero is not a legal period, so such a load is dropped
    w_period_nxt = r_period;
    if (bus.load && (bus.period_in != '0)) begin
      w_period_nxt = bus.period_in;
    end

    if (bus.stop) begin
      // A stop outside RUN is a no-op but still suppresses a same-cycle start
      if (r_state == S_RUN) begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_presc_nxt = '0;
      end
    end else if (bus.start) begin
      // The period register's pre-edge value is used, so a load on the
      // same edge only takes effect from the next wrap or start.
      w_state_nxt      = S_RUN;
      w_count_nxt      = '0;
      w_presc_nxt      = '0;
      w_mode_nxt       = bus.mode;
      w_period_eff_nxt = r_period;
      w_done_nxt       = 1'b0;
    end else if ((r_state == S_RUN) && bus.enable) begin
      if (w_step) begin
        w_presc_nxt = '0;
        if (w_last) begin
          w_count_nxt      = '0;
          w_tick_nxt       = 1'b1;
          w_period_eff_nxt = r_period;
          if (r_mode) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  assign bus.tick  = r_tick;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.count = r_count;

endmodule

// File: doc/pulse_timer.md
PULSE_TIMER -- requirements
Module: pulse_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the count and period.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 10: period after reset; must be 1..2^WIDTH-1.
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per count step; must be >= 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: 1 = advance; 0 = freeze prescaler and count.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin or restart a run.
REQ-008 SHALL have port stop, input, 1: one-cycle request to abort the run.
REQ-009 SHALL have port mode, input, 1: run mode, sampled on start; 0 = periodic, 1 = one-shot.
REQ-010 SHALL have port load, input, 1: write strobe for period_in.
REQ-011 SHALL have port period_in, input, WIDTH: new period value.
REQ-012 SHALL have port tick, output, 1: one-cycle pulse on each period completion.
REQ-013 SHALL have port busy, output, 1: high while in RUN.
REQ-014 SHALL have port done, output, 1: sticky flag set when a one-shot run completes.
REQ-015 SHALL have port count, output, WIDTH: current count value.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-017 SHALL hold a period register; on load with period_in != 0 it SHALL take period_in on that edge; load with period_in == 0 SHALL be ignored.
REQ-018 SHALL hold period_eff, copied from the period register on start and on every wrap; a load SHALL never alter the step in progress.
REQ-019 SHALL, on start in any state (stop low), enter RUN and clear count and prescaler to 0, latch mode, reload period_eff, clear done, and not emit tick.
REQ-020 SHALL, on stop in RUN, enter IDLE and clear count and prescaler to 0; stop SHALL win over a same-cycle start, and stop in IDLE/DONE SHALL have no effect.
REQ-021 SHALL, in RUN with enable=1, generate a step when prescaler == PRESCALE-1 and then reset the prescaler to 0; otherwise it SHALL increment the prescaler.
REQ-022 SHALL, on a step with count != period_eff-1, set count to count+1.
REQ-023 SHALL, on a step with count == period_eff-1 (wrap), set count to 0 and raise tick for exactly the following cycle.
REQ-024 SHALL, on wrap in periodic mode, stay in RUN; on wrap in one-shot mode, go to DONE, set done=1 and busy=0.
REQ-025 SHALL, with enable=0, hold count and prescaler and keep tick=0; state changes from start/stop SHALL still apply.
REQ-026 SHALL ignore mode changes during RUN.
REQ-027 SHALL, in IDLE and DONE, hold count=0 and tick=0; done SHALL stay 1 in DONE until start or reset.
REQ-028 SHALL, with period 1 and PRESCALE 1, tick every enabled cycle in periodic mode.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, force IDLE, count=0, prescaler=0, tick=0, busy=0, done=0, period=period_eff=DEFAULT_PERIOD, and mode=periodic.
REQ-030 SHALL give reset priority over start, stop, load and enable, including mid-run.

Verification
REQ-031 SHALL cover: defaults, enable=1, start pulse at edge E0 (mode 0) -> tick high after E10, E20, E30; count 0..9 repeating; busy=1.
REQ-032 SHALL cover: PRESCALE=4, load 3, start (mode 0) -> tick every 12 cycles; count steps every 4 cycles.
REQ-033 SHALL cover: load 5, start with mode 1 -> single tick after 5 cycles, then done=1, busy=0, count=0, no further ticks; a new start clears done.
REQ-034 SHALL cover: a mid-run load of 4 while period 10 -> current period finishes at 10, following periods are 4; load of 0 -> period unchanged.
REQ-035 SHALL cover: enable low for 3 cycles mid-period -> tick delayed by exactly 3 cycles and count frozen; start+stop in the same cycle -> IDLE, count=0.
REQ-036 SHALL cover: reset asserted at count=7 in RUN -> next cycle all outputs 0 and period back to 10; after reset, start -> first tick 10 cycles later.
